div_ctrl: RTL
=============

Name: div_ctrl

Overview:
Multi-cycle divide controller for the execute stage. It sequences an iterative radix-2 divider for DIV/DIVU and stalls the pipeline while the divide runs. It presents the quotient/remainder with a HI/LO write strobe and aborts cleanly on exception flush. It sits between the E-stage decode signals (divide request, signedness) and the HI/LO register file.

Parameters:
WIDTH, 32, operand and result width in bits
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
start_i  in  1  E-stage instruction is DIV or DIVU
signed_i  in  1  1 = DIV (signed), 0 = DIVU
opa_i  in  WIDTH  dividend (rs value)
opb_i  in  WIDTH  divisor (rt value)
flush_i  in  1  exception/eret flush of E stage
ext_stall_i  in  1  stall of E stage from another source (memory, etc.)
stall_o  out  1  hold E stage and earlier stages
valid_o  out  1  result valid this cycle
hilo_we_o  out  1  write HI/LO; equals valid_o & ~flush_i
hi_o  out  WIDTH  remainder
lo_o  out  WIDTH  quotient

Behaviour:
- Reset: state=IDLE, counter=0, stall_o=0, valid_o=0, hilo_we_o=0, hi_o=0, lo_o=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start_i & ~flush_i captures opa_i, opb_i and signed_i into internal registers; stall_o=1 combinationally in this cycle.
  - If the captured divisor is 0, go to DONE with hi=0, lo=0.
  - Otherwise load the magnitudes (|a|, |b| when signed, else raw values), record the quotient sign (sa^sb) and the remainder sign (sa), clear the counter, and go to BUSY.
- BUSY: one shift-subtract iteration per cycle, stall_o=1. When counter==WIDTH-1, go to DONE. With WIDTH=32 this gives exactly 32 BUSY cycles.
- DONE:
  - stall_o=0, valid_o=1.
  - Sign fixup is applied before the result reaches the output registers: quotient negated if the signs differ; remainder negated if the dividend was negative.
  - Result registers remain stable.
  - If ext_stall_i=1, stay in DONE with the result held, valid_o stays 1 and no restart occurs. Otherwise go to IDLE.
- Latency: start seen at cycle 0, first valid_o at cycle 33 for WIDTH=32. For a zero divisor, valid_o comes at cycle 1.
- Capture rule: opa_i, opb_i and signed_i are sampled only at IDLE start. Changes while in BUSY are ignored.
- No back-to-back restart: start_i is not sampled in DONE. The next division needs a fresh IDLE cycle.
- flush_i:
  - Highest priority, in any state. The next state is IDLE and the counter is cleared.
  - valid_o and hilo_we_o are forced to 0 in the flush cycle.
  - stall_o=0 in the flush cycle.
  - flush_i together with start_i in IDLE: start is ignored.
- rst has priority over flush_i and over everything else.
- Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0. This comes naturally from magnitude arithmetic with WIDTH-bit wrap.
- Arithmetic: the partial remainder is WIDTH+1 bits wide; compare/subtract is against the zero-extended divisor; quotient bits shift in from the LSB.

Decomposition:
- Shared package/header holds:
  - state encoding constants DIV_IDLE, DIV_BUSY, DIV_DONE (2-bit);
  - DIV_CYCLES = WIDTH;
  - the HI/LO write-enable naming shared with the HI/LO register.
- Sub-module div_core contains the iterative unsigned shift-subtract datapath. Its interface is: load, step, dividend/divisor in, quotient/remainder out, with one step per cycle.
- div_ctrl owns the FSM, the counter, sign handling, stall/valid generation and flush.

Test Plan:
- Signed positive: DIV 7/2, start at cycle 0 -> stall_o=1 for cycles 0–32; at cycle 33 valid_o=1, lo_o=3, hi_o=1.
- Signed negative: DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF at cycle 33.
- Unsigned wide: DIVU 0xFFFFFFFF/2 -> lo_o=0x7FFFFFFF, hi_o=1.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- Divide-by-zero: DIV 5/0 -> valid_o=1 at cycle 1, hi_o=0, lo_o=0, stall_o=1 only in cycle 0.
- Flush and hold:
  - flush_i pulsed at cycle 10 of a BUSY divide -> stall_o=0 from cycle 10, no valid_o/hilo_we_o. A new DIVU 9/3 then yields lo_o=3, hi_o=0 after 33 cycles.
  - Separately, ext_stall_i=1 for 3 cycles during DONE -> valid_o held 4 cycles with a stable result and no restart.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and HI/LO write naming for the divide controller
package div_ctrl_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;
  typedef struct packed {
    logic                 hilo_we;
    logic [DIV_WIDTH-1:0] hi;
    logic [DIV_WIDTH-1:0] lo;
  } hilo_wr_t;
endpackage

// File: rtl/div_core.sv
// div_core: iterative unsigned radix-2 shift-subtract divider, one step per cycle
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);
  logic [WIDTH:0]   rem, shl, diff, rem_n;
  logic [WIDTH-1:0] quo, dvs;
  logic             fits;
  // quo holds the unconsumed dividend bits on top and the quotient bits shifting in below
  always_comb begin
    shl = (WIDTH+1)'({rem, quo[WIDTH-1]});
    diff = shl - {1'b0, dvs};
    fits = ~diff[WIDTH];
    rem_n = fits ? diff : shl;
    quo_nxt = {quo[WIDTH-2:0], fits};
    rem_nxt = rem_n[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
      dvs <= divisor;
    end else if (step) begin
      rem <= rem_n;
      quo <= quo_nxt;
    end
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle DIV/DIVU sequencer with pipeline stall, HI/LO write strobe and flush abort
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             flush_i,
  input  logic             ext_stall_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, sa, sb, go, busy, last, zero_b;
  logic [WIDTH-1:0] mag_a, mag_b, quo_nxt, rem_nxt;
  always_comb begin
    sa = signed_i & opa_i[WIDTH-1];
    sb = signed_i & opb_i[WIDTH-1];
    mag_a = sa ? -opa_i : opa_i;
    mag_b = sb ? -opb_i : opb_i;
    zero_b = opb_i == '0;
    go = state == DIV_IDLE && start_i && !flush_i;
    busy = state == DIV_BUSY;
    last = busy && cnt == CNT_W'(WIDTH-1);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = flush_i ? DIV_IDLE :
                state == DIV_IDLE ? (start_i ? (zero_b ? DIV_DONE : DIV_BUSY) : DIV_IDLE) :
                busy ? (last ? DIV_DONE : DIV_BUSY) :
                state == DIV_DONE && ext_stall_i ? DIV_DONE : DIV_IDLE;
  end
  always_comb begin
    stall_o = !rst && (go || (busy && !flush_i));
    valid_o = state == DIV_DONE && !flush_i;
    hilo_we_o = valid_o && !flush_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (go) begin
      cnt <= '0;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      if (zero_b) begin
        hi_o <= '0;
        lo_o <= '0;
      end
    end else if (busy) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        lo_o <= neg_q ? -quo_nxt : quo_nxt;
        hi_o <= neg_r ? -rem_nxt : rem_nxt;
      end
    end
  end
  div_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk),
    .rst(rst),
    .load(go),
    .step(busy && !flush_i),
    .dividend(mag_a),
    .divisor(mag_b),
    .quo_nxt(quo_nxt),
    .rem_nxt(rem_nxt)
  );
endmodule
